// File: rtl/psum_wr_pkg.sv
// Shared definitions for the psum write controller: FSM states, stall codes
// and default widths.
package psum_wr_pkg;

    localparam int PSUM_WIDTH_DEF = 24;
    localparam int CNT_WIDTH_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUM,
        ST_PUSH,
        ST_REPORT,
        ST_FINISH
    } state_e;

    localparam logic [1:0] STALL_WAIT   = 2'b00;
    localparam logic [1:0] STALL_NEXT   = 2'b10;
    localparam logic [1:0] STALL_FINISH = 2'b11;

endpackage

// File: rtl/psum_add_sat.sv
// Combinational signed adder with optional clamp to the signed W-bit range.
// Ports: a_i, b_i (operands), sum_o (W-bit result), ovf_o (true overflow).
module psum_add_sat
    import psum_wr_pkg::*;
#(
    parameter int W      = PSUM_WIDTH_DEF,
    parameter bit SAT_EN = 1'b0
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0]   wide;
    logic [W-1:0] clamp;

    // One guard bit: overflow when the sign and guard bit disagree.
    assign wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    assign ovf_o = wide[W] ^ wide[W-1];

    // Guard bit carries the true sign of the unbounded sum.
    assign clamp = wide[W] ? {1'b1, {(W-1){1'b0}}}
                           : {1'b0, {(W-1){1'b1}}};

    assign sum_o = (SAT_EN && ovf_o) ? clamp : wide[W-1:0];

endmodule

// File: rtl/psum_write_controller.sv
// Adds the stored psum to each finished result and pushes it downstream
// over valid/ready, reporting a stall code to the main controller.
// Ports: clk, reset (async, high), chip_en, global_rst (sync clear),
//   done/result/psum_mode/psum_in/psum_in_valid/psum_limit (request side),
//   out_ready/out_data/out_valid (write side), stall, wr_count,
//   sat_flag, drop_err (status).
// Build option: define PSUM_SATURATE_EN to clamp overflowing sums and
//   drive sat_flag; otherwise sums wrap and sat_flag stays 0.
module psum_write_controller
    import psum_wr_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chip_en,
    input  logic                  global_rst,
    input  logic                  done,
    input  logic [PSUM_WIDTH-1:0] result,
    input  logic                  psum_mode,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    input  logic                  psum_in_valid,
    input  logic [CNT_WIDTH-1:0]  psum_limit,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [1:0]            stall,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic                  sat_flag,
    output logic                  drop_err
);

`ifdef PSUM_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e                state_q;
    logic [PSUM_WIDTH-1:0] op_a_q;
    logic [PSUM_WIDTH-1:0] op_b_q;
    logic [PSUM_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic [1:0]            stall_q;
    logic [CNT_WIDTH-1:0]  wr_count_q;
    logic                  sat_q;
    logic                  drop_q;

    logic [PSUM_WIDTH-1:0] acc_d;
    logic                  ovf;
    logic [CNT_WIDTH-1:0]  wr_count_d;
    logic                  last_d;

    psum_add_sat #(
        .W      (PSUM_WIDTH),
        .SAT_EN (SAT_EN)
    ) u_add (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (acc_d),
        .ovf_o (ovf)
    );

    assign wr_count_d = wr_count_q + CNT_WIDTH'(1);

    // A zero limit is a single-psum job, so any write ends it.
    assign last_d = (wr_count_d == psum_limit) || (psum_limit == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= STALL_WAIT;
            wr_count_q  <= '0;
            sat_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else if (chip_en) begin
            if (global_rst) begin
                state_q     <= ST_IDLE;
                op_a_q      <= '0;
                op_b_q      <= '0;
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
                stall_q     <= STALL_WAIT;
                wr_count_q  <= '0;
                sat_q       <= 1'b0;
                drop_q      <= 1'b0;
            end else begin
                if (done && (state_q != ST_IDLE)) begin
                    drop_q <= 1'b1;
                end
                unique case (state_q)
                    ST_IDLE: begin
                        stall_q <= STALL_WAIT;
                        if (done) begin
                            op_a_q <= result;
                            if (psum_mode && psum_in_valid) begin
                                op_b_q <= psum_in;
                            end else begin
                                op_b_q <= '0;
                            end
                            if (psum_mode && !psum_in_valid) begin
                                drop_q <= 1'b1;
                            end
                            state_q <= ST_SUM;
                        end
                    end
                    ST_SUM: begin
                        out_data_q  <= acc_d;
                        out_valid_q <= 1'b1;
                        if (SAT_EN && ovf) begin
                            sat_q <= 1'b1;
                        end
                        state_q <= ST_PUSH;
                    end
                    ST_PUSH: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            wr_count_q  <= wr_count_d;
                            stall_q     <= last_d ? STALL_FINISH
                                                  : STALL_NEXT;
                            state_q     <= ST_REPORT;
                        end
                    end
                    ST_REPORT: begin
                        // Stall code was decided at the handshake.
                        if (stall_q == STALL_FINISH) begin
                            state_q <= ST_FINISH;
                        end else begin
                            stall_q <= STALL_WAIT;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_FINISH: begin
                        stall_q <= STALL_FINISH;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign stall     = stall_q;
    assign wr_count  = wr_count_q;
    assign sat_flag  = sat_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_psum_write_controller.sv
// Self-checking bench for psum_write_controller: vector table, directed
// multi-cycle sequences and randomized jobs against a reference model.
module tb_psum_write_controller;

`ifdef PSUM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        chip_en;
    logic        global_rst;
    logic        done;
    logic [23:0] result;
    logic        psum_mode;
    logic [23:0] psum_in;
    logic        psum_in_valid;
    logic [7:0]  psum_limit;
    logic        out_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic [1:0]  stall;
    logic [7:0]  wr_count;
    logic        sat_flag;
    logic        drop_err;

    int n_chk  = 0;
    int n_fail = 0;

    psum_write_controller dut (
        .clk           (clk),
        .reset         (reset),
        .chip_en       (chip_en),
        .global_rst    (global_rst),
        .done          (done),
        .result        (result),
        .psum_mode     (psum_mode),
        .psum_in       (psum_in),
        .psum_in_valid (psum_in_valid),
        .psum_limit    (psum_limit),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .stall         (stall),
        .wr_count      (wr_count),
        .sat_flag      (sat_flag),
        .drop_err      (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] r;
        logic        m;
        logic [23:0] p;
        logic        pv;
        logic [7:0]  lim;
        logic [23:0] ed;
        logic [1:0]  es;
        logic [7:0]  ec;
        logic        edrop;
        logic        esat;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic grst();
        global_rst = 1'b1;
        tick();
        global_rst = 1'b0;
    endtask

    // Starts in an IDLE cycle; ends in the cycle after REPORT.
    task automatic txn(input logic [23:0] r, input logic m,
                       input logic [23:0] p, input logic pv,
                       input logic [7:0] lim, input logic [23:0] ed,
                       input logic [1:0] es, input logic [7:0] ec,
                       input string nm);
        result = r; psum_mode = m; psum_in = p;
        psum_in_valid = pv; psum_limit = lim;
        out_ready = 1'b1; done = 1'b1;
        tick();
        done = 1'b0; psum_in_valid = 1'b0;
        chk({nm, " t+1 valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({nm, " t+2 valid"}, 32'(out_valid), 32'd1);
        chk({nm, " t+2 data"}, 32'(out_data), 32'(ed));
        chk({nm, " t+2 stall"}, 32'(stall), 32'd0);
        tick();
        chk({nm, " t+3 valid"}, 32'(out_valid), 32'd0);
        chk({nm, " t+3 stall"}, 32'(stall), 32'(es));
        chk({nm, " t+3 count"}, 32'(wr_count), 32'(ec));
        tick();
        chk({nm, " t+4 stall"}, 32'(stall),
            (es == 2'b11) ? 32'd3 : 32'd0);
    endtask

    function automatic logic [23:0] ref_sum(input int a, input int b,
                                            output bit ovf);
        longint s;
        s = longint'(a) + longint'(b);
        ovf = (s > 8388607) || (s < -8388608);
        if (ovf && SAT) s = (s > 0) ? 8388607 : -8388608;
        return 24'(s);
    endfunction

    function automatic int rnd_op();
        int k;
        k = int'($urandom_range(0, 3));
        if (k == 0) return 8388607 - int'($urandom_range(0, 3));
        if (k == 1) return -8388608 + int'($urandom_range(0, 3));
        return int'($urandom_range(0, 16777215)) - 8388608;
    endfunction

    initial begin
        reset = 1'b1; chip_en = 1'b1; global_rst = 1'b0; done = 1'b0;
        result = '0; psum_mode = 1'b0; psum_in = '0;
        psum_in_valid = 1'b0; psum_limit = 8'd3; out_ready = 1'b1;

        tbl[0] = '{24'd100, 1'b0, 24'd0, 1'b0, 8'd3,
                   24'd100, 2'b10, 8'd1, 1'b0, 1'b0};
        tbl[1] = '{24'd100, 1'b1, 24'hFFFFD8, 1'b1, 8'd3,
                   24'h00003C, 2'b10, 8'd2, 1'b0, 1'b0};
        tbl[2] = '{24'hFFFFFB, 1'b1, 24'hFFFFF9, 1'b1, 8'd10,
                   24'hFFFFF4, 2'b10, 8'd3, 1'b0, 1'b0};
        tbl[3] = '{24'd7, 1'b1, 24'd99, 1'b0, 8'd10,
                   24'd7, 2'b10, 8'd4, 1'b1, 1'b0};
        tbl[4] = '{24'h7FFFFF, 1'b1, 24'd1, 1'b1, 8'd10,
                   SAT ? 24'h7FFFFF : 24'h800000, 2'b10, 8'd5, 1'b1, SAT};
        tbl[5] = '{24'h800000, 1'b1, 24'hFFFFFF, 1'b1, 8'd10,
                   SAT ? 24'h800000 : 24'h7FFFFF, 2'b10, 8'd6, 1'b1, SAT};
        tbl[6] = '{24'd1, 1'b0, 24'd5, 1'b1, 8'd7,
                   24'd1, 2'b11, 8'd7, 1'b1, SAT};

        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset data", 32'(out_data), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset count", 32'(wr_count), 32'd0);
        chk("reset sat", 32'(sat_flag), 32'd0);
        chk("reset drop", 32'(drop_err), 32'd0);

        for (int i = 0; i < 7; i++) begin
            txn(tbl[i].r, tbl[i].m, tbl[i].p, tbl[i].pv, tbl[i].lim,
                tbl[i].ed, tbl[i].es, tbl[i].ec, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d drop", i), 32'(drop_err),
                32'(tbl[i].edrop));
            chk($sformatf("vec%0d sat", i), 32'(sat_flag),
                32'(tbl[i].esat));
        end

        // FINISH holds and ignores a new request
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("finish stall", 32'(stall), 32'd3);
            chk("finish valid", 32'(out_valid), 32'd0);
            tick();
        end
        grst();
        chk("grst stall", 32'(stall), 32'd0);
        chk("grst count", 32'(wr_count), 32'd0);
        chk("grst drop", 32'(drop_err), 32'd0);
        chk("grst sat", 32'(sat_flag), 32'd0);

        // Backpressure: value held for five cycles
        result = 24'd100; psum_mode = 1'b1; psum_in = 24'hFFFFD8;
        psum_in_valid = 1'b1; psum_limit = 8'd3; done = 1'b1;
        tick();
        done = 1'b0; psum_in_valid = 1'b0; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp data", 32'(out_data), 32'h3C);
            chk("bp stall", 32'(stall), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp report stall", 32'(stall), 32'd2);
        chk("bp count", 32'(wr_count), 32'd1);
        chk("bp valid off", 32'(out_valid), 32'd0);
        tick();

        // Job end at limit 2
        grst();
        txn(24'd11, 1'b0, 24'd0, 1'b0, 8'd2, 24'd11, 2'b10, 8'd1, "job1");
        txn(24'd12, 1'b0, 24'd0, 1'b0, 8'd2, 24'd12, 2'b11, 8'd2, "job2");
        for (int i = 0; i < 4; i++) begin
            chk("job hold", 32'(stall), 32'd3);
            tick();
        end
        grst();
        chk("job grst stall", 32'(stall), 32'd0);
        chk("job grst count", 32'(wr_count), 32'd0);

        // done together with global_rst: clear wins
        result = 24'd9; psum_mode = 1'b0; done = 1'b1; global_rst = 1'b1;
        tick();
        done = 1'b0; global_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("dg valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("dg drop", 32'(drop_err), 32'd0);
        txn(24'd9, 1'b0, 24'd0, 1'b0, 8'd4, 24'd9, 2'b10, 8'd1, "dg");

        // chip_en low freezes PUSH even with out_ready high
        grst();
        result = 24'd21; psum_mode = 1'b0; psum_limit = 8'd5; done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chip_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ce valid", 32'(out_valid), 32'd1);
            chk("ce count", 32'(wr_count), 32'd0);
        end
        chip_en = 1'b1;
        tick();
        chk("ce count after", 32'(wr_count), 32'd1);
        chk("ce stall after", 32'(stall), 32'd2);
        tick();

        // Async reset during a stalled PUSH
        result = 24'd5; psum_mode = 1'b0; done = 1'b1;
        tick();
        done = 1'b0; out_ready = 1'b0;
        tick();
        chk("ar pre valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar valid", 32'(out_valid), 32'd0);
        chk("ar stall", 32'(stall), 32'd0);
        chk("ar count", 32'(wr_count), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar idle valid", 32'(out_valid), 32'd0);
        txn(24'd6, 1'b0, 24'd0, 1'b0, 8'd5, 24'd6, 2'b10, 8'd1, "ar");

        // Randomized jobs against the reference model
        for (int job = 0; job < 12; job++) begin
            int  mcount;
            bit  mdrop;
            bit  msat;
            bit  fin;
            int  lim;
            grst();
            mcount = 0; mdrop = 1'b0; msat = 1'b0; fin = 1'b0;
            lim = ($urandom_range(0, 4) == 0) ? 0
                                               : int'($urandom_range(1, 5));
            psum_limit = 8'(lim);
            for (int t = 0; t < 8 && !fin; t++) begin
                int a;
                int b;
                bit m;
                bit pv;
                bit ovf;
                bit rdy;
                logic [23:0] exp_d;
                logic [1:0]  exp_s;
                a = rnd_op(); b = rnd_op();
                m = 1'($urandom_range(0, 1));
                pv = 1'($urandom_range(0, 3) != 0);
                result = 24'(a); psum_in = 24'(b);
                psum_mode = m; psum_in_valid = pv;
                exp_d = ref_sum(a, (m && pv) ? b : 0, ovf);
                msat = msat | (ovf && SAT);
                mdrop = mdrop | (m && !pv);
                out_ready = 1'($urandom_range(0, 1));
                done = 1'b1;
                tick();
                done = 1'b0; psum_in_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                tick();
                for (int w = 0; w < 40; w++) begin
                    chk("rnd valid", 32'(out_valid), 32'd1);
                    chk("rnd data", 32'(out_data), 32'(exp_d));
                    rdy = (w == 39) ? 1'b1 : 1'($urandom_range(0, 1));
                    out_ready = rdy;
                    tick();
                    if (rdy) break;
                end
                mcount = (mcount + 1) % 256;
                exp_s = (mcount == lim || lim == 0) ? 2'b11 : 2'b10;
                chk("rnd stall", 32'(stall), 32'(exp_s));
                chk("rnd count", 32'(wr_count), 32'(mcount));
                chk("rnd valid off", 32'(out_valid), 32'd0);
                chk("rnd drop", 32'(drop_err), 32'(mdrop));
                chk("rnd sat", 32'(sat_flag), 32'(msat));
                tick();
                fin = (exp_s == 2'b11);
                chk("rnd next stall", 32'(stall), fin ? 32'd3 : 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
